// File: rtl/claw_rope_controller.sv
// claw_rope_controller: per-frame motion generator for the claw rope.
// Swings the rope angle back and forth, extends the rope on a grab and
// retracts it on a hook, a length limit or when the end point leaves the
// screen. The rope end point is produced relative to a fixed anchor.
//
// Optional feature macro: CLAW_WEIGHT_SLOWDOWN_EN
//   When defined, a hooked load slows the retract speed by its weight
//   (never below 1 pixel per frame). When undefined, load_weight is unused.
module claw_rope_controller #(
  parameter int X_START       = 300,
  parameter int Y_START       = 0,
  parameter int MIN_LEN       = 20,
  parameter int MAX_LEN       = 400,
  parameter int EXTEND_SPEED  = 4,
  parameter int RETRACT_SPEED = 4,
  parameter int SWING_DIV     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        grab_key,
  input  logic        hooked,
  input  logic [2:0]  load_weight,
  output logic [10:0] x_end,
  output logic [10:0] y_end,
  output logic [1:0]  claw_state,
  output logic        grab_done,
  output logic        grab_hooked
);

  typedef enum logic [1:0] {
    SWING   = 2'd0,
    EXTEND  = 2'd1,
    RETRACT = 2'd2
  } state_t;

  localparam int DIV_W = (SWING_DIV > 1) ? $clog2(SWING_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWING_DIV - 1);

  localparam logic [8:0] MIN_L = 9'(MIN_LEN);
  localparam logic [8:0] MAX_L = 9'(MAX_LEN);
  localparam logic [8:0] EXT_S = 9'(EXTEND_SPEED);
  localparam logic [8:0] RET_S = 9'(RETRACT_SPEED);

  localparam logic [3:0] IDX_CENTER = 4'd7;
  localparam logic [3:0] IDX_LEFT   = 4'd0;
  localparam logic [3:0] IDX_RIGHT  = 4'd14;

  localparam logic signed [10:0] X0     = 11'(X_START);
  localparam logic signed [10:0] Y0     = 11'(Y_START);
  localparam logic signed [10:0] Y_IDLE = 11'(Y_START + MIN_LEN);

  // Motion state
  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [8:0]       len_q, len_d;
  logic             hook_q;
  logic             done_d;

  // Position pipeline
  logic signed [10:0] x_q, y_q;
  logic signed [10:0] x_calc, y_calc;
  logic [3:0]         mag;
  logic [7:0]         sin_mag, cos_mag;
  logic [16:0]        prod_x, prod_y;
  logic [9:0]         dx, dy;

  // Helpers for the next-state logic
  logic [3:0] idx_step;
  logic [9:0] len_sum;
  logic [8:0] ext_len;
  logic [8:0] spd;
  logic [9:0] ret_floor;
  logic [8:0] ret_len;
  logic       off_screen;

  assign idx_step   = dir_q ? (idx_q + 4'd1) : (idx_q - 4'd1);
  assign len_sum    = {1'b0, len_q} + {1'b0, EXT_S};
  assign ext_len    = (len_sum >= {1'b0, MAX_L}) ? MAX_L : len_sum[8:0];
  assign ret_floor  = {1'b0, MIN_L} + {1'b0, spd};
  assign ret_len    = ({1'b0, len_q} >= ret_floor) ? (len_q - spd) : MIN_L;
  assign off_screen = (x_q < 11'sd0) || (x_q > 11'sd639) || (y_q > 11'sd479);

`ifdef CLAW_WEIGHT_SLOWDOWN_EN
  // Heavier hooked loads retract more slowly, never below one pixel per frame
  always_comb begin
    spd = RET_S;
    if (hook_q) begin
      if ({6'b0, load_weight} >= RET_S) spd = 9'd1;
      else spd = RET_S - {6'b0, load_weight};
    end
  end
`else
  logic unused_load;
  assign spd         = RET_S;
  assign unused_load = ^load_weight;
`endif

  // Next-state logic: motion only advances on a frame tick
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    div_d   = div_q;
    len_d   = len_q;
    done_d  = 1'b0;
    if (startOfFrame) begin
      case (state_q)
        SWING: begin
          if (grab_key) begin
            state_d = EXTEND;
          end else if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_step;
            if ((idx_step == IDX_LEFT) || (idx_step == IDX_RIGHT)) dir_d = ~dir_q;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        EXTEND: begin
          if (hook_q || (len_sum >= {1'b0, MAX_L}) || off_screen) begin
            state_d = RETRACT;
            len_d   = ext_len;
          end else begin
            len_d = len_sum[8:0];
          end
        end
        RETRACT: begin
          len_d = ret_len;
          if (ret_len == MIN_L) begin
            state_d = SWING;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = SWING;
        end
      endcase
    end
  end

  // Motion state register and the completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SWING;
      idx_q       <= IDX_CENTER;
      dir_q       <= 1'b1;
      div_q       <= '0;
      len_q       <= MIN_L;
      grab_done   <= 1'b0;
      grab_hooked <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dir_q       <= dir_d;
      div_q       <= div_d;
      len_q       <= len_d;
      grab_done   <= done_d;
      grab_hooked <= done_d & hook_q;
    end
  end

  // Hook latch: armed on any clock while extending, cleared after the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hook_q <= 1'b0;
    end else if (grab_done) begin
      hook_q <= 1'b0;
    end else if (hooked && (state_q == EXTEND)) begin
      hook_q <= 1'b1;
    end
  end

  // Sine/cosine magnitude lookup in 10 degree steps, scaled by 128
  assign mag = (idx_q >= IDX_CENTER) ? (idx_q - IDX_CENTER) : (IDX_CENTER - idx_q);

  always_comb begin
    sin_mag = 8'd0;
    cos_mag = 8'd128;
    case (mag)
      4'd0: begin sin_mag = 8'd0;   cos_mag = 8'd128; end
      4'd1: begin sin_mag = 8'd22;  cos_mag = 8'd126; end
      4'd2: begin sin_mag = 8'd44;  cos_mag = 8'd120; end
      4'd3: begin sin_mag = 8'd64;  cos_mag = 8'd111; end
      4'd4: begin sin_mag = 8'd82;  cos_mag = 8'd98;  end
      4'd5: begin sin_mag = 8'd98;  cos_mag = 8'd82;  end
      4'd6: begin sin_mag = 8'd111; cos_mag = 8'd64;  end
      4'd7: begin sin_mag = 8'd120; cos_mag = 8'd44;  end
      default: begin sin_mag = 8'd0; cos_mag = 8'd128; end
    endcase
  end

  // Unsigned offsets from the anchor; the sign is applied afterwards so the
  // left and right halves of the swing are exact mirrors
  assign prod_x = {8'b0, len_q} * {9'b0, sin_mag};
  assign prod_y = {8'b0, len_q} * {9'b0, cos_mag};
  assign dx     = 10'(prod_x >> 7);
  assign dy     = 10'(prod_y >> 7);

  always_comb begin
    x_calc = X0;
    if (idx_q > IDX_CENTER) x_calc = X0 + $signed({1'b0, dx});
    else                    x_calc = X0 - $signed({1'b0, dx});
    y_calc = Y0 + $signed({1'b0, dy});
  end

  // End point register, one clock behind the motion state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= X0;
      y_q <= Y_IDLE;
    end else begin
      x_q <= x_calc;
      y_q <= y_calc;
    end
  end

  assign x_end      = x_q;
  assign y_end      = y_q;
  assign claw_state = state_q;

endmodule

// File: tb/tb_claw_rope_controller.sv
// Testbench for claw_rope_controller.
// A reference model predicts each frame's end point and state plus every
// grab completion; a monitor compares them as the DUT presents them.
module tb_claw_rope_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        grab_key;
  logic        hooked;
  logic [2:0]  load_weight;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic [1:0]  claw_state;
  logic        grab_done;
  logic        grab_hooked;

  claw_rope_controller dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .grab_key     (grab_key),
    .hooked       (hooked),
    .load_weight  (load_weight),
    .x_end        (x_end),
    .y_end        (y_end),
    .claw_state   (claw_state),
    .grab_done    (grab_done),
    .grab_hooked  (grab_hooked)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int st;
  } frame_t;

  frame_t frameQ[$];
  int     doneQ[$];

  int compareCount = 0;
  int failCount    = 0;

  // Reference model state
  int mState, mI, mDir, mLen, mDiv, mHook, mX, mY;

  function automatic int sinTab(input int a);
    case (a)
      0: return 0;   1: return 22;  2: return 44;  3: return 64;
      4: return 82;  5: return 98;  6: return 111; default: return 120;
    endcase
  endfunction

  function automatic int cosTab(input int a);
    case (a)
      0: return 128; 1: return 126; 2: return 120; 3: return 111;
      4: return 98;  5: return 82;  6: return 64;  default: return 44;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelPos();
    int a, dx;
    a  = (mI >= 7) ? (mI - 7) : (7 - mI);
    dx = (mLen * sinTab(a)) >> 7;
    mX = (mI > 7) ? (300 + dx) : (300 - dx);
    mY = (mLen * cosTab(a)) >> 7;
  endtask

  task automatic modelReset();
    mState = 0; mI = 7; mDir = 1; mLen = 20; mDiv = 0; mHook = 0;
    mX = 300; mY = 20;
  endtask

  task automatic modelTick(input logic g);
    int sum, spd, lw;
    frame_t f;
    lw = int'(load_weight);
    case (mState)
      0: begin
        if (g) mState = 1;
        else if (mDiv == 1) begin
          mDiv = 0;
          mI = mI + mDir;
          if (mI == 0 || mI == 14) mDir = -mDir;
        end else mDiv = mDiv + 1;
      end
      1: begin
        sum = mLen + 4;
        if (mHook == 1 || sum >= 400 || mX < 0 || mX > 639 || mY > 479) begin
          mState = 2;
          mLen = (sum > 400) ? 400 : sum;
        end else mLen = sum;
      end
      default: begin
`ifdef CLAW_WEIGHT_SLOWDOWN_EN
        spd = (mHook == 1) ? (((4 - lw) < 1) ? 1 : (4 - lw)) : 4;
`else
        spd = 4;
        lw  = 0;
`endif
        mLen = (mLen - spd < 20) ? 20 : (mLen - spd);
        if (mLen == 20) begin
          mState = 0;
          doneQ.push_back(mHook);
          mHook = 0;
        end
      end
    endcase
    modelPos();
    f.x = mX; f.y = mY; f.st = mState;
    frameQ.push_back(f);
  endtask

  // One 8-clock frame: tick in the first cycle, optional hook pulse later
  task automatic applyStimulus(input logic g, input logic h);
    @(posedge clk); #1;
    startOfFrame = 1'b1;
    grab_key     = g;
    modelTick(g);
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    grab_key     = 1'b0;
    @(posedge clk); #1;
    if (h) begin
      hooked = 1'b1;
      if (mState == 1) mHook = 1;
    end
    @(posedge clk); #1;
    hooked = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    modelReset();
    reset = 1'b0;
  endtask

  // Monitor: compares the end point two clocks after each tick and every done pulse
  logic sofD1 = 1'b0, sofD2 = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    int h;
    if (sofD2) begin
      if (frameQ.size() == 0) begin
        checkOutput("frame queue underflow", 1, 0);
      end else begin
        f = frameQ.pop_front();
        checkOutput("x_end", int'($signed(x_end)), f.x);
        checkOutput("y_end", int'($signed(y_end)), f.y);
        checkOutput("claw_state", int'(claw_state), f.st);
      end
    end
    if (grab_done === 1'b1) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected grab_done", 1, 0);
      end else begin
        h = doneQ.pop_front();
        checkOutput("grab_hooked", int'(grab_hooked), h);
      end
    end
    sofD2 = sofD1;
    sofD1 = startOfFrame;
  end

  initial begin
    int n;
    reset = 1'b1; startOfFrame = 1'b0; grab_key = 1'b0; hooked = 1'b0;
    load_weight = 3'd0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset x_end", int'($signed(x_end)), 300);
    checkOutput("reset y_end", int'($signed(y_end)), 20);
    checkOutput("reset claw_state", int'(claw_state), 0);
    checkOutput("reset grab_done", int'(grab_done), 0);
    checkOutput("reset grab_hooked", int'(grab_hooked), 0);
    reset = 1'b0;

    // Swing to the right end, then to the left end
    $display("[TB] swing");
    repeat (14) applyStimulus(1'b0, 1'b0);
    checkOutput("right end x_end", int'($signed(x_end)), 318);
    checkOutput("right end y_end", int'($signed(y_end)), 6);
    repeat (28) applyStimulus(1'b0, 1'b0);
    checkOutput("left end x_end", int'($signed(x_end)), 282);
    checkOutput("left end y_end", int'($signed(y_end)), 6);
    repeat (4) applyStimulus(1'b0, 1'b0);

    // Full extend to the length limit and back at the centre angle
    $display("[TB] full extend");
    doReset();
    applyStimulus(1'b1, 1'b0);
    repeat (95) applyStimulus(1'b0, 1'b0);
    checkOutput("limit y_end", int'($signed(y_end)), 400);
    checkOutput("limit x_end", int'($signed(x_end)), 300);
    checkOutput("limit claw_state", int'(claw_state), 2);
    repeat (100) applyStimulus(1'b0, 1'b0);
    checkOutput("after retract claw_state", int'(claw_state), 0);

    // Asynchronous reset in the middle of a retract
    $display("[TB] reset mid-retract");
    applyStimulus(1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset x_end", int'($signed(x_end)), 300);
    checkOutput("async reset y_end", int'($signed(y_end)), 20);
    checkOutput("async reset claw_state", int'(claw_state), 0);
    @(posedge clk); #1;
    modelReset();
    reset = 1'b0;

    // Hook at length 100, unloaded and with two load weights
    for (int k = 0; k < 3; k++) begin
      $display("[TB] hook run %0d", k);
      doReset();
      load_weight = (k == 0) ? 3'd0 : ((k == 1) ? 3'd3 : 3'd7);
      applyStimulus(1'b1, 1'b0);
      repeat (19) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("hook len y_end", int'($signed(y_end)), 100);
      repeat (110) applyStimulus(1'b0, 1'b0);
    end
    load_weight = 3'd0;

    // Grab at -60 degrees: hooks during swing are ignored, off-screen retracts
    $display("[TB] off-screen grab");
    doReset();
    n = 0;
    while (mI != 1 && n < 80) begin
      applyStimulus(1'b0, (n % 5) == 0);
      n++;
    end
    applyStimulus(1'b1, 1'b0);
    repeat (82) applyStimulus(1'b0, 1'b0);
    checkOutput("off-screen x_end", int'($signed(x_end)), -1);
    checkOutput("off-screen claw_state", int'(claw_state), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("off-screen retract claw_state", int'(claw_state), 2);
    repeat (100) applyStimulus(1'b0, 1'b0);

    repeat (4) @(posedge clk);
    checkOutput("pending frames", frameQ.size(), 0);
    checkOutput("missed grab_done pulses", doneQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
